// File: rtl/sigma_delta_dac_pkg.sv
// Shared constants and width derivations for the sigma-delta DAC path.
// Contents:
//   DEF_*            default build parameters (24-bit PCM, 3rd-order CIC, R=64)
//   U1_GUARD/U2_GUARD  headroom bits of the modulator integrators above IN_WIDTH
//   fs_exp()         FS = 2**fs_exp(IN_WIDTH)
//   log2_ratio()     log2 of the (power-of-two) interpolation ratio
//   comb_width()     comb chain width
//   integ_width()    integrator chain width
//   cic_shift()      output shift for unity DC gain
//   u1_width()/u2_width()  modulator state widths
package sigma_delta_dac_pkg;

  localparam int DEF_IN_WIDTH  = 24;
  localparam int DEF_CIC_ORDER = 3;
  localparam int DEF_CIC_R     = 64;

  localparam int U1_GUARD = 3;
  localparam int U2_GUARD = 5;

  function automatic int fs_exp(input int w);
    return w - 1;
  endfunction

  function automatic int log2_ratio(input int r);
    return $clog2(r);
  endfunction

  function automatic int comb_width(input int w, input int n);
    return w + n;
  endfunction

  function automatic int integ_width(input int w, input int n, input int r);
    return w + n * log2_ratio(r);
  endfunction

  function automatic int cic_shift(input int n, input int r);
    return (n - 1) * log2_ratio(r);
  endfunction

  function automatic int u1_width(input int w);
    return w + U1_GUARD;
  endfunction

  function automatic int u2_width(input int w);
    return w + U2_GUARD;
  endfunction

endpackage

// File: rtl/sd_mod2.sv
// Second-order 1-bit delta-sigma modulator.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_tick          bit-rate strobe; state advances only on this strobe
//   i_v             signed input sample, full scale = 2**(IN_WIDTH-1)
//   o_data          bitstream (1 = +FS, 0 = -FS), held between ticks
//   o_valid         one-cycle pulse, 1 clock after i_tick
module sd_mod2
  import sigma_delta_dac_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_tick,
  input  logic signed [IN_WIDTH-1:0] i_v,
  output logic                       o_data,
  output logic                       o_valid
);

  localparam int U1_W = u1_width(IN_WIDTH);
  localparam int U2_W = u2_width(IN_WIDTH);
  localparam int FSE  = fs_exp(IN_WIDTH);

  // FS in the first-stage sum width, 2*FS in the second-stage sum width
  localparam logic signed [U1_W:0] FS1   = {{(U1_W-FSE){1'b0}}, 1'b1, {FSE{1'b0}}};
  localparam logic signed [U2_W:0] FS2X2 = {{(U2_W-FSE-1){1'b0}}, 1'b1, {(FSE+1){1'b0}}};

  logic signed [U1_W-1:0] r_u1;
  logic signed [U2_W-1:0] r_u2;
  logic                   r_data;
  logic                   r_valid;

  logic signed [U1_W:0]   w_fb1;
  logic signed [U2_W:0]   w_fb2;
  logic signed [U1_W:0]   w_s1;
  logic signed [U2_W:0]   w_s2;
  logic signed [U1_W-1:0] w_u1;
  logic signed [U2_W-1:0] w_u2;

  // Sums carry one extra bit so they never wrap; saturation then clamps
  // whenever the top two bits disagree.
  always_comb begin
    w_fb1 = r_data ? FS1 : -FS1;
    w_fb2 = r_data ? FS2X2 : -FS2X2;

    w_s1 = {r_u1[U1_W-1], r_u1}
         + {{(U1_W+1-IN_WIDTH){i_v[IN_WIDTH-1]}}, i_v}
         - w_fb1;
    if (w_s1[U1_W] != w_s1[U1_W-1]) begin
      w_u1 = {w_s1[U1_W], {(U1_W-1){~w_s1[U1_W]}}};
    end else begin
      w_u1 = w_s1[U1_W-1:0];
    end

    w_s2 = {r_u2[U2_W-1], r_u2}
         + {{(U2_W+1-U1_W){w_u1[U1_W-1]}}, w_u1}
         - w_fb2;
    if (w_s2[U2_W] != w_s2[U2_W-1]) begin
      w_u2 = {w_s2[U2_W], {(U2_W-1){~w_s2[U2_W]}}};
    end else begin
      w_u2 = w_s2[U2_W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_u1    <= '0;
      r_u2    <= '0;
      r_data  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_tick;
      if (i_tick) begin
        r_u1   <= w_u1;
        r_u2   <= w_u2;
        r_data <= ~w_u2[U2_W-1];
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/sigma_delta_dac.sv
// PCM to 1-bit bitstream: one-entry input buffer, CIC interpolator (xR),
// second-order delta-sigma modulator.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   pcm_in, pcm_valid        signed PCM sample and its valid
//   pcm_ready                registered, equals !buffer_full (0 in reset)
//   bit_tick                 single-cycle output bit-rate strobe
//   data_out, data_out_valid bitstream and its update pulse
//   underrun                 pulse when a frame boundary finds the buffer empty
module sigma_delta_dac
  import sigma_delta_dac_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int CIC_ORDER = DEF_CIC_ORDER,
  parameter int CIC_R     = DEF_CIC_R
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [IN_WIDTH-1:0] pcm_in,
  input  logic                       pcm_valid,
  output logic                       pcm_ready,
  input  logic                       bit_tick,
  output logic                       data_out,
  output logic                       data_out_valid,
  output logic                       underrun
);

  localparam int          LOG2_R = log2_ratio(CIC_R);
  localparam int          COMB_W = comb_width(IN_WIDTH, CIC_ORDER);
  localparam int          INT_W  = integ_width(IN_WIDTH, CIC_ORDER, CIC_R);
  localparam int          SHIFT  = cic_shift(CIC_ORDER, CIC_R);
  localparam int unsigned N      = CIC_ORDER;

  logic signed [IN_WIDTH-1:0] r_buf;
  logic                       r_buf_full;
  logic                       r_ready;
  logic                       r_underrun;
  logic [LOG2_R-1:0]          r_phase;
  logic signed [COMB_W-1:0]   r_dly [N];
  logic signed [COMB_W-1:0]   r_comb_out;
  logic signed [INT_W-1:0]    r_int [N];

  logic                       w_accept;
  logic                       w_boundary;
  logic                       w_first;
  logic                       w_full_nxt;
  logic signed [COMB_W-1:0]   w_ci [N+1];
  logic signed [INT_W-1:0]    w_ii [N+1];
  logic signed [INT_W-1:0]    w_sh;
  logic [INT_W-IN_WIDTH:0]    w_hi;
  logic signed [IN_WIDTH-1:0] w_v;

  assign w_accept   = pcm_valid && r_ready;
  // CIC_R is a power of two, so phase == CIC_R-1 is the all-ones pattern
  assign w_boundary = bit_tick && (&r_phase);
  assign w_first    = bit_tick && (r_phase == '0);
  assign w_full_nxt = w_accept || (r_buf_full && !w_boundary);

  always_comb begin
    // Comb input: buffered sample, or the previous sample (held in the
    // first delay) when the buffer is empty, which makes that frame's
    // first comb difference zero.
    w_ci[0] = r_buf_full ? {{(COMB_W-IN_WIDTH){r_buf[IN_WIDTH-1]}}, r_buf} : r_dly[0];
    for (int unsigned k = 0; k < N; k++) begin
      w_ci[k+1] = w_ci[k] - r_dly[k];
    end

    // Zero insertion: the comb result feeds the integrators only on the
    // first tick of each frame. The chain is combinational so a new sample
    // reaches the modulator on that same tick.
    w_ii[0] = w_first ? {{(INT_W-COMB_W){r_comb_out[COMB_W-1]}}, r_comb_out} : '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_ii[k+1] = r_int[k] + w_ii[k];
    end

    w_sh = w_ii[N] >>> SHIFT;
    w_hi = w_sh[INT_W-1:IN_WIDTH-1];
    if ((&w_hi) || !(|w_hi)) begin
      w_v = w_sh[IN_WIDTH-1:0];
    end else begin
      w_v = {w_sh[INT_W-1], {(IN_WIDTH-1){~w_sh[INT_W-1]}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
      r_phase    <= '0;
      r_comb_out <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        r_dly[k] <= '0;
        r_int[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_buf <= pcm_in;
      end
      r_buf_full <= w_full_nxt;
      r_ready    <= !w_full_nxt;
      r_underrun <= w_boundary && !r_buf_full;
      if (bit_tick) begin
        r_phase <= r_phase + LOG2_R'(1);
        for (int unsigned k = 0; k < N; k++) begin
          r_int[k] <= w_ii[k+1];
        end
      end
      if (w_boundary) begin
        r_comb_out <= w_ci[N];
        for (int unsigned k = 0; k < N; k++) begin
          r_dly[k] <= w_ci[k];
        end
      end
    end
  end

  assign pcm_ready = r_ready;
  assign underrun  = r_underrun;

  sd_mod2 #(
    .IN_WIDTH(IN_WIDTH)
  ) u_mod (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_tick  (bit_tick),
    .i_v     (w_v),
    .o_data  (data_out),
    .o_valid (data_out_valid)
  );

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Directed bench for sigma_delta_dac (IN_WIDTH=24, CIC_ORDER=3, CIC_R=64).
// A cycle-level model of buffer occupancy and phase predicts pcm_ready,
// underrun and data_out_valid every clock; density checks use the fact that
// over a window ones-zeros = (sum(v) - delta_u1)/FS with |u1| < 4*FS.
module tb_sigma_delta_dac;

  logic               clk;
  logic               rst_n;
  logic signed [23:0] pcm_in;
  logic               pcm_valid;
  logic               pcm_ready;
  logic               bit_tick;
  logic               data_out;
  logic               data_out_valid;
  logic               underrun;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned m_phase;
  bit          m_full;
  int unsigned cnt_ones;
  int unsigned cnt_bits;
  int unsigned cnt_under;
  int unsigned cnt_acc;

  sigma_delta_dac #(
    .IN_WIDTH (24),
    .CIC_ORDER(3),
    .CIC_R    (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pcm_in        (pcm_in),
    .pcm_valid     (pcm_valid),
    .pcm_ready     (pcm_ready),
    .bit_tick      (bit_tick),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .underrun      (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol = 0);
    longint diff;
    n_checks++;
    diff = got - exp;
    if (diff > tol || diff < -tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic clear_counts();
    cnt_ones  = 0;
    cnt_bits  = 0;
    cnt_under = 0;
    cnt_acc   = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    pcm_valid = 1'b0;
    bit_tick  = 1'b0;
    pcm_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", pcm_ready, 0);
    check("rst_dout", data_out, 0);
    check("rst_dvalid", data_out_valid, 0);
    check("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_rise", pcm_ready, 1);
    m_phase = 0;
    m_full  = 1'b0;
  endtask

  // nticks bit_ticks, one every 'period' clocks; feed holds pcm_valid high
  task automatic run(input int unsigned nticks, input int unsigned period,
                     input bit feed, input logic signed [23:0] val);
    for (int unsigned t = 0; t < nticks; t++) begin
      for (int unsigned c = 0; c < period; c++) begin
        bit tk;
        bit acc;
        bit bnd;
        bit exp_under;
        bit full_nxt;
        tk        = (c == period - 1);
        bit_tick  = tk;
        pcm_valid = feed;
        pcm_in    = val;
        acc       = feed && pcm_ready;
        bnd       = tk && (m_phase == 63);
        exp_under = bnd && !m_full;
        full_nxt  = acc || (m_full && !bnd);
        @(posedge clk);
        #1;
        check("underrun", underrun, exp_under);
        check("ready", pcm_ready, !full_nxt);
        check("dvalid", data_out_valid, tk);
        m_full = full_nxt;
        if (tk) m_phase = (m_phase + 1) % 64;
        if (acc) cnt_acc++;
        if (underrun) cnt_under++;
        if (data_out_valid) begin
          cnt_bits++;
          if (data_out) cnt_ones++;
        end
      end
    end
    bit_tick  = 1'b0;
    pcm_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_counts();

    // Idle after reset: zero signal, underrun every frame, 50% density
    do_reset();
    clear_counts();
    run(4096, 4, 1'b0, '0);
    check("idle_underruns", cnt_under, 64);
    check("idle_bits", cnt_bits, 4096);
    check("idle_ones", cnt_ones, 2048, 4);

    // DC +FS/2
    do_reset();
    run(320, 1, 1'b1, 24'sd4194304);
    clear_counts();
    run(4096, 1, 1'b1, 24'sd4194304);
    check("dc_half_ones", cnt_ones, 3072, 4);
    check("dc_half_under", cnt_under, 0);

    // DC -0.75*FS
    do_reset();
    run(320, 1, 1'b1, -24'sd6291456);
    clear_counts();
    run(4096, 1, 1'b1, -24'sd6291456);
    check("dc_neg_ones", cnt_ones, 512, 8);
    check("dc_neg_under", cnt_under, 0);

    // Handshake at max tick rate: one beat per frame
    do_reset();
    clear_counts();
    run(320, 1, 1'b1, 24'sd1000);
    check("hs_accepts", cnt_acc, 5);
    check("hs_under", cnt_under, 0);

    // Overrange for 10 frames, then zero
    do_reset();
    run(384, 1, 1'b1, 24'sd8388607);
    clear_counts();
    run(256, 1, 1'b1, 24'sd8388607);
    check("ovr_all_ones", cnt_ones, 256);
    run(576, 1, 1'b1, '0);
    clear_counts();
    run(1024, 1, 1'b1, '0);
    check("ovr_recover_ones", cnt_ones, 512, 4);

    // Asynchronous reset mid-frame
    do_reset();
    run(100, 1, 1'b1, 24'sd4194304);
    bit_tick  = 1'b1;
    pcm_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ready", pcm_ready, 0);
    check("async_dout", data_out, 0);
    check("async_dvalid", data_out_valid, 0);
    check("async_underrun", underrun, 0);
    do_reset();
    clear_counts();
    run(63, 1, 1'b0, '0);
    check("restart_pre_boundary", cnt_under, 0);
    run(1, 1, 1'b0, '0);
    check("restart_boundary", cnt_under, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
